dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Memory-side responder for the data-memory interface: accepts load/store requests from the CPU memory stage, applies RV32I load/store sizing, and returns load data.
- Sits behind the memory-stage CPU port as the target of the data-memory request/response handshake.
- Models a synchronous word-organised RAM with a programmable number of wait states.
- Flags misaligned and out-of-range accesses.

Parameters:
- NB_WORD, 32, data width in bits.
- NB_ADDR, 32, byte-address width.
- DEPTH_WORDS, 1024, number of 32-bit words stored; must be a power of two.
- WAIT_CYCLES, 1, extra cycles between request acceptance and response; range 0..15.

Ports:
- i_clock  input  1  rising-edge clock.
- i_reset_n  input  1  asynchronous active-low reset.
- i_req_valid  input  1  request present.
- o_req_ready  output  1  responder can accept a request this cycle.
- i_req_we  input  1  1 = store, 0 = load.
- i_req_addr  input  NB_ADDR  byte address.
- i_req_wdata  input  NB_WORD  store data, LSB-aligned.
- i_req_funct3  input  3  RV32I load/store funct3.
- o_rsp_valid  output  1  one-cycle response pulse.
- o_rsp_rdata  output  NB_WORD  load result, sign- or zero-extended; 0 for stores and errors.
- o_rsp_error  output  1  valid with o_rsp_valid; access was misaligned, out of range or an illegal funct3.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low.
- Reset values: state=IDLE, o_req_ready=1, o_rsp_valid=0, o_rsp_rdata=0, o_rsp_error=0, wait counter=0. Memory contents are not reset.
- Handshake: a request is accepted when i_req_valid && o_req_ready on a rising edge. Request fields are captured into internal registers at acceptance. Only one request is outstanding at a time.
- FSM states:
  - IDLE: ready=1. On accept, go to WAIT if WAIT_CYCLES>0, else to RESP. Load the counter with WAIT_CYCLES.
  - WAIT: ready=0. Decrement the counter; go to RESP when the counter reaches 1.
  - RESP: ready=0. Perform the access, drive o_rsp_valid=1 for exactly one cycle, then return to IDLE.
- Latency: the response is asserted WAIT_CYCLES+1 cycles after the acceptance edge. With WAIT_CYCLES=0 this is the cycle after acceptance.
- Back-to-back throughput: a new request can be accepted in the cycle after the response.
- Stores (performed in RESP):
  - SB (000): byte lane addr[1:0].
  - SH (001): halfword lane addr[1].
  - SW (010): full word.
  - Other byte lanes are unchanged.
- Loads: the RAM word is read in RESP, then sized and extended.
  - LB=000 and LH=001 sign-extend.
  - LBU=100 and LHU=101 zero-extend.
  - LW=010 returns the full word.
- Error conditions:
  - Misaligned: halfword with addr[0]=1, or word with addr[1:0]!=0.
  - Out of range: addr[NB_ADDR-1:2] >= DEPTH_WORDS.
  - Illegal funct3: store funct3 > 010, or load funct3 of 011, 110 or 111.
- On error: no memory write, o_rsp_rdata=0, o_rsp_error=1, and the response timing is unchanged.
- i_req_valid while busy is ignored; the requester must hold it until accepted.
- Reset asserted mid-operation discards the outstanding request. No write occurs unless RESP had already completed on an earlier edge.
- Word index = addr[log2(DEPTH_WORDS)+1:2].

Optional Feature:
- Macro: DMEM_RESPONDER_STATS_EN.
- When defined:
  - Adds outputs o_load_count [15:0] and o_store_count [15:0]. Both reset to 0.
  - Each increments on its RESP cycle for non-error accesses only and saturates at 16'hFFFF.
  - Adds output o_err_sticky [0:0], set by any error response and cleared only by reset.
- When undefined: these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- WAIT_CYCLES=2: SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> o_rsp_valid 3 cycles after each accept, rdata=0xDEADBEEF, error=0, ready low during WAIT/RESP.
- After the word above: SB addr 0x11 data 0x000000AA, then LW 0x10 -> 0xDEADAAEF; LB 0x11 -> 0xFFFFFFAA; LBU 0x11 -> 0x000000AA.
- SH addr 0x12 data 0x00008001, then LH 0x12 -> 0xFFFF8001, LHU 0x12 -> 0x00008001; LW 0x10 -> 0x8001AAEF.
- LW 0x13 -> error=1, rdata=0; SW 0x4000 (DEPTH 1024) -> error=1, and a following LW 0x0 shows the location unchanged.
- WAIT_CYCLES=0: two back-to-back loads with valid held high -> accepts on alternating cycles, responses one cycle after each accept.
- Reset low during WAIT of SW 0x20 data 0x12345678 -> outputs return to reset values immediately; LW 0x20 after reset does not return 0x12345678 (location preloaded with 0).

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder: RV32I data-memory responder with a word-organised RAM and programmable wait states.
// Optional access statistics are enabled with `define DMEM_RESPONDER_STATS_EN.
//
// state | meaning
// IDLE  | ready; waiting for a request
// WAIT  | wait states counting down
// RESP  | access performed, response registered
module dmem_responder #(
  parameter int NB_WORD     = 32,
  parameter int NB_ADDR     = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic               i_clock,
  input  logic               i_reset_n,
  input  logic               i_req_valid,
  output logic               o_req_ready,
  input  logic               i_req_we,
  input  logic [NB_ADDR-1:0] i_req_addr,
  input  logic [NB_WORD-1:0] i_req_wdata,
  input  logic [2:0]         i_req_funct3,
  output logic               o_rsp_valid,
  output logic [NB_WORD-1:0] o_rsp_rdata,
  output logic               o_rsp_error
`ifdef DMEM_RESPONDER_STATS_EN
  ,
  output logic [15:0]        o_load_count,
  output logic [15:0]        o_store_count,
  output logic [0:0]         o_err_sticky
`endif
);

  localparam int AW    = $clog2(DEPTH_WORDS);
  localparam int NB_BE = NB_WORD / 8;
  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  logic               we_q, we_d;
  logic [NB_ADDR-1:0] addr_q, addr_d;
  logic [NB_WORD-1:0] wdata_q, wdata_d;
  logic [2:0]         funct3_q, funct3_d;

  logic               rsp_valid_q, rsp_valid_d;
  logic [NB_WORD-1:0] rsp_rdata_q, rsp_rdata_d;
  logic               rsp_error_q, rsp_error_d;

  logic [NB_WORD-1:0] mem [DEPTH_WORDS];

  logic               accept;
  logic               in_resp;
  logic               illegal_f3;
  logic               misaligned;
  logic               out_of_range;
  logic               acc_err;
  logic [AW-1:0]      word_idx;
  logic [NB_WORD-1:0] rd_word;
  logic [7:0]         ld_byte;
  logic [15:0]        ld_half;
  logic [NB_WORD-1:0] load_val;
  logic [NB_BE-1:0]   wr_be;
  logic [NB_WORD-1:0] wr_lanes;
  logic [NB_WORD-1:0] wr_word;
  logic               do_write;

  // State and request registers
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      funct3_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      funct3_q    <= funct3_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_error_q <= rsp_error_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          cnt_d   = WAIT_LD;
          state_d = (WAIT_CYCLES > 0) ? ST_WAIT : ST_RESP;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM outputs
  always_comb begin
    o_req_ready = (state_q == ST_IDLE);
    in_resp     = (state_q == ST_RESP);
  end

  assign accept = i_req_valid && o_req_ready;

  always_comb begin
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    funct3_d = funct3_q;
    if (accept) begin
      we_d     = i_req_we;
      addr_d   = i_req_addr;
      wdata_d  = i_req_wdata;
      funct3_d = i_req_funct3;
    end
  end

  // Access checks on the captured request; DEPTH_WORDS is a power of two, so
  // any set address bit above the word index means out of range.
  always_comb begin
    if (we_q) begin
      illegal_f3 = (funct3_q > 3'b010);
    end else begin
      illegal_f3 = (funct3_q == 3'b011) || (funct3_q[2:1] == 2'b11);
    end
    misaligned   = ((funct3_q[1:0] == 2'b01) && addr_q[0]) ||
                   ((funct3_q[1:0] == 2'b10) && (addr_q[1:0] != 2'b00));
    out_of_range = |addr_q[NB_ADDR-1:AW+2];
    acc_err      = illegal_f3 || misaligned || out_of_range;
    word_idx     = addr_q[AW+1:2];
  end

  assign rd_word = mem[word_idx];

  always_comb begin
    ld_byte = 8'(rd_word >> {addr_q[1:0], 3'b000});
    ld_half = 16'(rd_word >> {addr_q[1], 4'b0000});
    case (funct3_q)
      3'b000:  load_val = {{(NB_WORD-8){ld_byte[7]}}, ld_byte};
      3'b001:  load_val = {{(NB_WORD-16){ld_half[15]}}, ld_half};
      3'b010:  load_val = rd_word;
      3'b100:  load_val = {{(NB_WORD-8){1'b0}}, ld_byte};
      3'b101:  load_val = {{(NB_WORD-16){1'b0}}, ld_half};
      default: load_val = '0;
    endcase
  end

  // Store lanes are replicated across the word and selected by byte enables
  always_comb begin
    case (funct3_q[1:0])
      2'b00: begin
        wr_be    = NB_BE'(1) << addr_q[1:0];
        wr_lanes = {NB_BE{wdata_q[7:0]}};
      end
      2'b01: begin
        wr_be    = addr_q[1] ? NB_BE'(4'b1100) : NB_BE'(4'b0011);
        wr_lanes = {(NB_BE/2){wdata_q[15:0]}};
      end
      default: begin
        wr_be    = '1;
        wr_lanes = wdata_q;
      end
    endcase
    wr_word = rd_word;
    for (int i = 0; i < NB_BE; i++) begin
      if (wr_be[i]) begin
        wr_word[8*i +: 8] = wr_lanes[8*i +: 8];
      end
    end
    do_write = in_resp && we_q && !acc_err;
  end

  always_ff @(posedge i_clock) begin
    if (do_write) begin
      mem[word_idx] <= wr_word;
    end
  end

  always_comb begin
    rsp_valid_d = in_resp;
    rsp_error_d = in_resp && acc_err;
    rsp_rdata_d = (in_resp && !we_q && !acc_err) ? load_val : '0;
  end

  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_rdata = rsp_rdata_q;
  assign o_rsp_error = rsp_error_q;

`ifdef DMEM_RESPONDER_STATS_EN
  logic [15:0] load_cnt_q, load_cnt_d;
  logic [15:0] store_cnt_q, store_cnt_d;
  logic        err_sticky_q, err_sticky_d;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      load_cnt_q   <= '0;
      store_cnt_q  <= '0;
      err_sticky_q <= 1'b0;
    end else begin
      load_cnt_q   <= load_cnt_d;
      store_cnt_q  <= store_cnt_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  always_comb begin
    load_cnt_d   = load_cnt_q;
    store_cnt_d  = store_cnt_q;
    err_sticky_d = err_sticky_q || (in_resp && acc_err);
    if (in_resp && !acc_err) begin
      if (we_q && (store_cnt_q != 16'hFFFF)) begin
        store_cnt_d = store_cnt_q + 16'd1;
      end
      if (!we_q && (load_cnt_q != 16'hFFFF)) begin
        load_cnt_d = load_cnt_q + 16'd1;
      end
    end
  end

  assign o_load_count  = load_cnt_q;
  assign o_store_count = store_cnt_q;
  assign o_err_sticky  = err_sticky_q;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance with zero wait states, one with two.
module tb_dmem_responder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic        valid_i [2];
  logic        we_i    [2];
  logic [31:0] addr_i  [2];
  logic [31:0] wdata_i [2];
  logic [2:0]  f3_i    [2];

  logic        ready0, ready2, rv0, rv2, err0, err2;
  logic [31:0] rd0, rd2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

`ifdef DMEM_RESPONDER_STATS_EN
  logic [15:0] lc0, sc0, lc2, sc2;
  logic [0:0]  es0, es2;
`endif

  dmem_responder #(.WAIT_CYCLES(0)) dut0 (
    .i_clock(clk), .i_reset_n(rst_n),
    .i_req_valid(valid_i[0]), .o_req_ready(ready0),
    .i_req_we(we_i[0]), .i_req_addr(addr_i[0]), .i_req_wdata(wdata_i[0]),
    .i_req_funct3(f3_i[0]),
    .o_rsp_valid(rv0), .o_rsp_rdata(rd0), .o_rsp_error(err0)
`ifdef DMEM_RESPONDER_STATS_EN
    , .o_load_count(lc0), .o_store_count(sc0), .o_err_sticky(es0)
`endif
  );

  dmem_responder #(.WAIT_CYCLES(2)) dut2 (
    .i_clock(clk), .i_reset_n(rst_n),
    .i_req_valid(valid_i[1]), .o_req_ready(ready2),
    .i_req_we(we_i[1]), .i_req_addr(addr_i[1]), .i_req_wdata(wdata_i[1]),
    .i_req_funct3(f3_i[1]),
    .o_rsp_valid(rv2), .o_rsp_rdata(rd2), .o_rsp_error(err2)
`ifdef DMEM_RESPONDER_STATS_EN
    , .o_load_count(lc2), .o_store_count(sc2), .o_err_sticky(es2)
`endif
  );

  function automatic logic ready_of(input int d);
    return (d == 0) ? ready0 : ready2;
  endfunction
  function automatic logic rv_of(input int d);
    return (d == 0) ? rv0 : rv2;
  endfunction
  function automatic logic err_of(input int d);
    return (d == 0) ? err0 : err2;
  endfunction
  function automatic logic [31:0] rd_of(input int d);
    return (d == 0) ? rd0 : rd2;
  endfunction

  // One request on instance d (0: no wait states, 1: two wait states)
  task automatic access(input int d, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [2:0] f3,
                        output logic [31:0] rd, output logic er);
    int  lat;
    int  exp_lat;
    bit  seen;
    exp_lat = (d == 0) ? 1 : 3;
    @(negedge clk);
    valid_i[d] = 1'b1; we_i[d] = we; addr_i[d] = addr; wdata_i[d] = wdata; f3_i[d] = f3;
    n_checks++;
    if (ready_of(d) !== 1'b1) begin
      n_fail++; $display("FAIL ready_idle d=%0d: got %b want 1", d, ready_of(d));
    end
    @(posedge clk); #1;
    valid_i[d] = 1'b0;
    n_checks++;
    if (ready_of(d) !== 1'b0) begin
      n_fail++; $display("FAIL ready_after_accept d=%0d: got %b want 0", d, ready_of(d));
    end
    seen = 0; lat = 0; rd = '0; er = 1'b0;
    for (int k = 1; k <= 12 && !seen; k++) begin
      @(posedge clk); #1;
      if (rv_of(d) === 1'b1) begin
        seen = 1; lat = k; rd = rd_of(d); er = err_of(d);
      end else begin
        n_checks++;
        if (ready_of(d) !== 1'b0) begin
          n_fail++; $display("FAIL ready_busy d=%0d cycle %0d: got %b want 0", d, k, ready_of(d));
        end
      end
    end
    n_checks++;
    if (!seen || lat != exp_lat) begin
      n_fail++; $display("FAIL latency d=%0d: got %0d (seen=%0d) want %0d", d, lat, seen, exp_lat);
    end
    @(posedge clk); #1;
    n_checks++;
    if (rv_of(d) !== 1'b0) begin
      n_fail++; $display("FAIL rsp_pulse d=%0d: valid still %b", d, rv_of(d));
    end
  endtask

  task automatic test_reset();
    #12;
    n_checks++;
    if ({ready0, rv0, err0, ready2, rv2, err2} !== 6'b100100) begin
      n_fail++; $display("FAIL reset_ctrl: got %b want 100100", {ready0, rv0, err0, ready2, rv2, err2});
    end
    n_checks++;
    if (rd0 !== 32'h0 || rd2 !== 32'h0) begin
      n_fail++; $display("FAIL reset_rdata: got %h/%h want 0/0", rd0, rd2);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_word();
    logic [31:0] rd; logic er;
    access(1, 1'b1, 32'h10, 32'hDEADBEEF, 3'b010, rd, er);
    n_checks++;
    if (rd !== 32'h0 || er !== 1'b0) begin
      n_fail++; $display("FAIL sw_rsp: got %h err %b want 0 err 0", rd, er);
    end
    access(1, 1'b0, 32'h10, 32'h0, 3'b010, rd, er);
    n_checks++;
    if (rd !== 32'hDEADBEEF || er !== 1'b0) begin
      n_fail++; $display("FAIL lw_word: got %h err %b want deadbeef err 0", rd, er);
    end
  endtask

  task automatic test_byte();
    logic [31:0] rd; logic er;
    access(1, 1'b1, 32'h11, 32'h000000AA, 3'b000, rd, er);
    access(1, 1'b0, 32'h10, 32'h0, 3'b010, rd, er);
    n_checks++;
    if (rd !== 32'hDEADAAEF || er !== 1'b0) begin
      n_fail++; $display("FAIL sb_merge: got %h want deadaaef", rd);
    end
    access(1, 1'b0, 32'h11, 32'h0, 3'b000, rd, er);
    n_checks++;
    if (rd !== 32'hFFFFFFAA || er !== 1'b0) begin
      n_fail++; $display("FAIL lb: got %h want ffffffaa", rd);
    end
    access(1, 1'b0, 32'h11, 32'h0, 3'b100, rd, er);
    n_checks++;
    if (rd !== 32'h000000AA || er !== 1'b0) begin
      n_fail++; $display("FAIL lbu: got %h want 000000aa", rd);
    end
  endtask

  task automatic test_half();
    logic [31:0] rd; logic er;
    access(1, 1'b1, 32'h12, 32'h00008001, 3'b001, rd, er);
    access(1, 1'b0, 32'h12, 32'h0, 3'b001, rd, er);
    n_checks++;
    if (rd !== 32'hFFFF8001 || er !== 1'b0) begin
      n_fail++; $display("FAIL lh: got %h want ffff8001", rd);
    end
    access(1, 1'b0, 32'h12, 32'h0, 3'b101, rd, er);
    n_checks++;
    if (rd !== 32'h00008001 || er !== 1'b0) begin
      n_fail++; $display("FAIL lhu: got %h want 00008001", rd);
    end
    access(1, 1'b0, 32'h10, 32'h0, 3'b010, rd, er);
    n_checks++;
    if (rd !== 32'h8001AAEF || er !== 1'b0) begin
      n_fail++; $display("FAIL sh_merge: got %h want 8001aaef", rd);
    end
    access(1, 1'b0, 32'h13, 32'h0, 3'b000, rd, er);
    n_checks++;
    if (rd !== 32'hFFFFFF80 || er !== 1'b0) begin
      n_fail++; $display("FAIL lb_top_lane: got %h want ffffff80", rd);
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic er;
    access(1, 1'b0, 32'h13, 32'h0, 3'b010, rd, er);
    n_checks++;
    if (rd !== 32'h0 || er !== 1'b1) begin
      n_fail++; $display("FAIL lw_misaligned: got %h err %b want 0 err 1", rd, er);
    end
    access(1, 1'b0, 32'h11, 32'h0, 3'b001, rd, er);
    n_checks++;
    if (rd !== 32'h0 || er !== 1'b1) begin
      n_fail++; $display("FAIL lh_misaligned: got %h err %b want 0 err 1", rd, er);
    end
    access(1, 1'b1, 32'h0, 32'h11223344, 3'b010, rd, er);
    access(1, 1'b1, 32'h4000, 32'h55555555, 3'b010, rd, er);
    n_checks++;
    if (rd !== 32'h0 || er !== 1'b1) begin
      n_fail++; $display("FAIL sw_out_of_range: got %h err %b want 0 err 1", rd, er);
    end
    access(1, 1'b1, 32'h0, 32'h66666666, 3'b100, rd, er);
    n_checks++;
    if (er !== 1'b1) begin
      n_fail++; $display("FAIL store_bad_f3: err %b want 1", er);
    end
    access(1, 1'b0, 32'h0, 32'h0, 3'b011, rd, er);
    n_checks++;
    if (rd !== 32'h0 || er !== 1'b1) begin
      n_fail++; $display("FAIL load_bad_f3: got %h err %b want 0 err 1", rd, er);
    end
    access(1, 1'b0, 32'h0, 32'h0, 3'b010, rd, er);
    n_checks++;
    if (rd !== 32'h11223344 || er !== 1'b0) begin
      n_fail++; $display("FAIL err_no_write: got %h want 11223344", rd);
    end
  endtask

  task automatic test_reset_mid_op();
    logic [31:0] rd; logic er;
    access(1, 1'b1, 32'h20, 32'h0, 3'b010, rd, er);
    @(negedge clk);
    valid_i[1] = 1'b1; we_i[1] = 1'b1; addr_i[1] = 32'h20;
    wdata_i[1] = 32'h12345678; f3_i[1] = 3'b010;
    @(posedge clk); #1;
    valid_i[1] = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({ready2, rv2, err2} !== 3'b100 || rd2 !== 32'h0) begin
      n_fail++; $display("FAIL reset_mid_op: got ctrl %b rdata %h want 100 0", {ready2, rv2, err2}, rd2);
    end
    @(negedge clk);
    rst_n = 1'b1;
    access(1, 1'b0, 32'h20, 32'h0, 3'b010, rd, er);
    n_checks++;
    if (rd !== 32'h0 || er !== 1'b0) begin
      n_fail++; $display("FAIL reset_no_write: got %h want 00000000", rd);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic er;
    access(0, 1'b1, 32'h0, 32'hCAFEF00D, 3'b010, rd, er);
    access(0, 1'b1, 32'h4, 32'h0BADC0DE, 3'b010, rd, er);
    @(negedge clk);
    valid_i[0] = 1'b1; we_i[0] = 1'b0; addr_i[0] = 32'h0; f3_i[0] = 3'b010;
    @(posedge clk); #1;
    n_checks++;
    if (ready0 !== 1'b0 || rv0 !== 1'b0) begin
      n_fail++; $display("FAIL b2b_accept1: ready %b valid %b want 0 0", ready0, rv0);
    end
    addr_i[0] = 32'h4;
    @(posedge clk); #1;
    n_checks++;
    if (rv0 !== 1'b1 || rd0 !== 32'hCAFEF00D || ready0 !== 1'b1) begin
      n_fail++; $display("FAIL b2b_rsp1: valid %b rdata %h ready %b want 1 cafef00d 1", rv0, rd0, ready0);
    end
    @(posedge clk); #1;
    n_checks++;
    if (rv0 !== 1'b0 || ready0 !== 1'b0) begin
      n_fail++; $display("FAIL b2b_accept2: valid %b ready %b want 0 0", rv0, ready0);
    end
    valid_i[0] = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (rv0 !== 1'b1 || rd0 !== 32'h0BADC0DE || err0 !== 1'b0) begin
      n_fail++; $display("FAIL b2b_rsp2: valid %b rdata %h err %b want 1 0badc0de 0", rv0, rd0, err0);
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      valid_i[i] = 1'b0; we_i[i] = 1'b0; addr_i[i] = '0; wdata_i[i] = '0; f3_i[i] = '0;
    end
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_errors();
    test_reset_mid_op();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
